// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC result serializer.
// Holds result width, FSM state encoding and B0 header layout.
package mac_pkg;

    localparam int RESULT_W = 17;

    // B0 header: mode flag in bit 7, result bit 16 in bit 0
    localparam int HDR_MODE_BIT = 7;
    localparam int HDR_MSB_BIT  = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND0 = 2'd1,
        SEND1 = 2'd2,
        SEND2 = 2'd3
    } state_t;

    function automatic logic [7:0] header_byte(input logic m,
                                               input logic msb);
        logic [7:0] b;
        b               = 8'h00;
        b[HDR_MODE_BIT] = m;
        b[HDR_MSB_BIT]  = msb;
        return b;
    endfunction

endpackage

// File: rtl/mac_result_fifo.sv
// Synchronous result FIFO with registered storage.
// Ports: clk, reset, push/pop strobes, data in/head out,
// full, empty and occupancy count.
module mac_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 18,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // A pop frees the head slot on the same edge, so a full FIFO
    // still accepts a push then.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mac_result_serializer.sv
// Buffers MAC results and sends each as 3 bytes over valid/ready.
// Ports: clk, reset, valid_output/final_output/mode in,
// byte_out/byte_valid/byte_ready out, overflow, fifo_count.
module mac_result_serializer
    import mac_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int RESULT_W   = mac_pkg::RESULT_W,
    localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid_output,
    input  logic [RESULT_W-1:0] final_output,
    input  logic                mode,
    input  logic                clear_overflow,
    output logic [7:0]          byte_out,
    output logic                byte_valid,
    input  logic                byte_ready,
    output logic                overflow,
    output logic [CW-1:0]       fifo_count
);

    localparam int EW = RESULT_W + 1;

    state_t        state;
    logic [EW-1:0] hold;
    logic [EW-1:0] head;
    logic          full;
    logic          empty;
    logic          pop;
    logic          drop;
    logic          xfer;

    assign xfer = byte_valid && byte_ready;

    // Refill from IDLE, or straight after the last byte of a result
    assign pop = !empty &&
                 ((state == IDLE) || (state == SEND2 && byte_ready));

    assign drop = valid_output && full && !pop;

    mac_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (valid_output),
        .pop   (pop),
        .din   ({mode, final_output}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            hold       <= '0;
            byte_out   <= 8'h00;
            byte_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!empty) begin
                        hold       <= head;
                        byte_out   <= header_byte(head[EW-1], head[16]);
                        byte_valid <= 1'b1;
                        state      <= SEND0;
                    end
                end
                SEND0: begin
                    if (xfer) begin
                        byte_out <= hold[15:8];
                        state    <= SEND1;
                    end
                end
                SEND1: begin
                    if (xfer) begin
                        byte_out <= hold[7:0];
                        state    <= SEND2;
                    end
                end
                SEND2: begin
                    if (xfer) begin
                        if (!empty) begin
                            hold     <= head;
                            byte_out <= header_byte(head[EW-1],
                                                    head[16]);
                            state    <= SEND0;
                        end else begin
                            byte_out   <= 8'h00;
                            byte_valid <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                end
                default: begin
                    byte_out   <= 8'h00;
                    byte_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    // Sticky drop flag; a drop on the clearing edge wins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mac_result_serializer.sv
// Scoreboard bench for mac_result_serializer.
// Expected bytes queued at stimulus time, checked on each transfer.
module tb_mac_result_serializer;

    logic        clk;
    logic        reset;
    logic        valid_output;
    logic [16:0] final_output;
    logic        mode;
    logic        clear_overflow;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready;
    logic        overflow;
    logic [2:0]  fifo_count;

    int vectors;
    int errors;
    int xfer_count;
    logic [7:0] sb [$];

    mac_result_serializer #(
        .FIFO_DEPTH (4),
        .RESULT_W   (17)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .valid_output   (valid_output),
        .final_output   (final_output),
        .mode           (mode),
        .clear_overflow (clear_overflow),
        .byte_out       (byte_out),
        .byte_valid     (byte_valid),
        .byte_ready     (byte_ready),
        .overflow       (overflow),
        .fifo_count     (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transfer monitor: a handshake seen at negedge completes next posedge
    always @(negedge clk) begin
        if (!reset && byte_valid && byte_ready) begin
            logic [7:0] exp;
            vectors++;
            xfer_count++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_byte got %h expected none",
                         byte_out);
            end else begin
                exp = sb.pop_front();
                if (byte_out !== exp) begin
                    errors++;
                    $display("FAIL byte_stream got %h expected %h",
                             byte_out, exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_result(input logic m, input logic [16:0] r);
        sb.push_back({m, 6'b0, r[16]});
        sb.push_back(r[15:8]);
        sb.push_back(r[7:0]);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
        vectors++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got %0d left expected 0",
                     sb.size());
        end
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        valid_output   = 1'b0;
        final_output   = '0;
        mode           = 1'b0;
        clear_overflow = 1'b0;
        byte_ready     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({byte_valid, byte_out, overflow, fifo_count} !== 13'h0) begin
            errors++;
            $display("FAIL reset_state got v=%b b=%h o=%b c=%0d expected 0",
                     byte_valid, byte_out, overflow, fifo_count);
        end
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_trinomial();
        byte_ready = 1'b1;
        valid_output = 1'b1;
        final_output = 17'd52;
        mode = 1'b1;
        expect_result(1'b1, 17'd52);
        tick();
        valid_output = 1'b0;
        @(negedge clk);
        vectors++;
        if (fifo_count !== 3'd1 || byte_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_push got c=%0d v=%b expected c=1 v=0",
                     fifo_count, byte_valid);
        end
        @(negedge clk);
        vectors++;
        if (byte_valid !== 1'b1 || byte_out !== 8'h80 ||
            fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL latency_pop got v=%b b=%h c=%0d expected 1 80 0",
                     byte_valid, byte_out, fifo_count);
        end
        drain();
        @(negedge clk);
        vectors++;
        if (byte_valid !== 1'b0 || byte_out !== 8'h00) begin
            errors++;
            $display("FAIL idle_after got v=%b b=%h expected 0 00",
                     byte_valid, byte_out);
        end
    endtask

    task automatic test_back_to_back();
        int run;
        byte_ready   = 1'b1;
        valid_output = 1'b1;
        final_output = 17'd72;
        mode         = 1'b0;
        expect_result(1'b0, 17'd72);
        tick();
        final_output = 17'h1FFFF;
        mode         = 1'b1;
        expect_result(1'b1, 17'h1FFFF);
        tick();
        valid_output = 1'b0;
        run = 0;
        for (int i = 0; i < 20 && !(run > 0 && !byte_valid); i++) begin
            @(negedge clk);
            if (byte_valid) run++;
        end
        vectors++;
        if (run != 6) begin
            errors++;
            $display("FAIL no_bubble got %0d valid cycles expected 6", run);
        end
        drain();
    endtask

    task automatic test_stall();
        byte_ready   = 1'b0;
        valid_output = 1'b1;
        final_output = 17'h0ABCD;
        mode         = 1'b0;
        expect_result(1'b0, 17'h0ABCD);
        tick();
        valid_output = 1'b0;
        for (int i = 0; i < 10 && !byte_valid; i++) tick();
        byte_ready = 1'b1;
        tick();
        byte_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (byte_valid !== 1'b1 || byte_out !== 8'hAB) begin
                errors++;
                $display("FAIL stall_hold got v=%b b=%h expected 1 ab",
                         byte_valid, byte_out);
            end
        end
        tick();
        byte_ready = 1'b1;
        drain();
    endtask

    task automatic test_overflow();
        byte_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            valid_output = 1'b1;
            final_output = 17'(i);
            mode         = 1'b0;
            expect_result(1'b0, 17'(i));
            tick();
        end
        valid_output = 1'b0;
        @(negedge clk);
        vectors++;
        if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL fill got c=%0d o=%b expected 4 0",
                     fifo_count, overflow);
        end
        // Full FIFO: push on the same edge as the SEND2 pop is accepted
        tick();
        byte_ready = 1'b1;
        tick();
        tick();
        valid_output = 1'b1;
        final_output = 17'd6;
        expect_result(1'b0, 17'd6);
        tick();
        // Drop with clear on the same edge: set wins
        byte_ready     = 1'b0;
        final_output   = 17'd7;
        clear_overflow = 1'b1;
        vectors++;
        if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_pop_push got c=%0d o=%b expected 4 0",
                     fifo_count, overflow);
        end
        tick();
        valid_output   = 1'b0;
        clear_overflow = 1'b0;
        @(negedge clk);
        vectors++;
        if (overflow !== 1'b1 || fifo_count !== 3'd4) begin
            errors++;
            $display("FAIL drop_set_wins got o=%b c=%0d expected 1 4",
                     overflow, fifo_count);
        end
        tick();
        xfer_count = 0;
        byte_ready = 1'b1;
        drain();
        @(negedge clk);
        vectors++;
        if (xfer_count != 15 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL drain15 got n=%0d o=%b expected 15 1",
                     xfer_count, overflow);
        end
        tick();
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        vectors++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL clear_ovf got %b expected 0", overflow);
        end
    endtask

    task automatic test_reset_mid();
        byte_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            valid_output = 1'b1;
            final_output = 17'h10000 + 17'(i);
            mode         = 1'b1;
            expect_result(1'b1, 17'h10000 + 17'(i));
            tick();
        end
        valid_output = 1'b0;
        byte_ready   = 1'b1;
        tick();
        byte_ready = 1'b0;
        @(posedge clk);
        #3 reset = 1'b1;
        sb.delete();
        #1;
        vectors++;
        if (byte_valid !== 1'b0 || fifo_count !== 3'd0 ||
            byte_out !== 8'h00) begin
            errors++;
            $display("FAIL async_reset got v=%b c=%0d b=%h expected 0 0 00",
                     byte_valid, fifo_count, byte_out);
        end
        tick();
        tick();
        reset      = 1'b0;
        byte_ready = 1'b1;
        xfer_count = 0;
        repeat (10) tick();
        vectors++;
        if (xfer_count != 0) begin
            errors++;
            $display("FAIL post_reset_quiet got %0d bytes expected 0",
                     xfer_count);
        end
        valid_output = 1'b1;
        final_output = 17'h01234;
        mode         = 1'b0;
        expect_result(1'b0, 17'h01234);
        tick();
        valid_output = 1'b0;
        drain();
    endtask

    initial begin
        vectors    = 0;
        errors     = 0;
        xfer_count = 0;
        test_reset();
        test_trinomial();
        test_back_to_back();
        test_stall();
        test_overflow();
        test_reset_mid();
        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
